// File: rtl/match_event_gen_if.sv
// Detection-event stream from match_event_gen towards the in-band packet builder.
// The head is presented on ev_valid and consumed on ev_valid & ev_ready.
interface match_event_gen_if #(
    parameter int TS_WIDTH = 32
);
    logic                ev_valid;
    logic                ev_ready;
    logic [TS_WIDTH-1:0] ev_ts;
    logic [3:0]          ev_hits;

    modport master (output ev_valid, ev_ts, ev_hits, input ev_ready);
    modport slave  (input ev_valid, ev_ts, ev_hits, output ev_ready);
endinterface

// File: rtl/match_event_gen.sv
// N-of-M confirmation of correlator decisions; an event appears on ev two cycles after the deciding valid.
// Backpressure: events queue in a registered-output FIFO; pushes into a full FIFO without a pop are counted as lost.
module match_event_gen #(
    parameter int TS_WIDTH   = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rxstrobe,
    input  logic        valid,
    input  logic        match,
    input  logic [31:0] cdata,
    input  logic [2:0]  cstate,
    input  logic        cwrite,
    match_event_gen_if.master ev,
    output logic [7:0]  overflow_cnt,
    output logic [15:0] debugbus
);
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_EVAL  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    typedef struct packed {
        logic [TS_WIDTH-1:0] ts;
        logic [3:0]          hits;
    } event_t;

    logic [15:0]         holdoff;
    logic [15:0]         hold_cnt;
    logic                enable;
    logic [3:0]          req_n;
    logic [3:0]          win_m;
    logic [TS_WIDTH-1:0] sample_cnt;
    logic [TS_WIDTH-1:0] cand_ts;
    logic [14:0]         hist;
    logic [1:0]          state;
    logic [3:0]          hits;

    event_t              mem [FIFO_DEPTH];
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       wr_ptr;
    logic [CNT_W-1:0]    fifo_cnt;
    logic                ev_vld_q;
    event_t              head;

    logic                cfg_load;
    logic                push;
    logic                pop;
    logic                full;
    logic                push_ok;
    logic                drop;
    event_t              push_dat;
    logic [AW-1:0]       rd_nxt;
    logic [CNT_W-1:0]    cnt_nxt;
    event_t              head_nxt;
    logic                cfg_unused;

    assign cfg_load   = cwrite && (cstate == 3'd1);
    assign cfg_unused = ^{cdata[15:10], cdata[8]};

    always_comb begin
        hits = '0;
        for (int i = 0; i < 15; i++)
            if (i < int'(win_m)) hits = hits + 4'(hist[i]);
    end

    always_comb begin
        push          = (state == S_EVAL) && (hits >= req_n) && enable && !cfg_load;
        push_dat.ts   = cand_ts;
        push_dat.hits = hits;
        pop           = ev_vld_q && ev.ev_ready;
        full          = (fifo_cnt == CNT_W'(FIFO_DEPTH));
        push_ok       = push && (!full || pop);
        drop          = push && !push_ok;
        rd_nxt        = rd_ptr + AW'(pop);
        cnt_nxt       = fifo_cnt + CNT_W'(push_ok) - CNT_W'(pop);
        // Head register is refilled from storage, or bypassed when the write lands on an empty queue.
        head_nxt      = head;
        if (cnt_nxt != '0)
            head_nxt = (push_ok && ((fifo_cnt - CNT_W'(pop)) == '0)) ? push_dat : mem[rd_nxt];
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
            ev_vld_q <= 1'b0;
            head     <= '0;
        end else begin
            rd_ptr   <= rd_nxt;
            wr_ptr   <= wr_ptr + AW'(push_ok);
            fifo_cnt <= cnt_nxt;
            ev_vld_q <= (cnt_nxt != '0);
            head     <= head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            holdoff      <= '0;
            enable       <= 1'b0;
            req_n        <= 4'd1;
            win_m        <= 4'd1;
            sample_cnt   <= '0;
            cand_ts      <= '0;
            hist         <= '0;
            hold_cnt     <= '0;
            state        <= S_IDLE;
            overflow_cnt <= '0;
        end else begin
            if (rxstrobe) sample_cnt <= sample_cnt + TS_WIDTH'(1);

            if (cfg_load)
                overflow_cnt <= '0;
            else if (drop && (overflow_cnt != 8'hFF))
                overflow_cnt <= overflow_cnt + 8'd1;

            if (cfg_load) begin
                holdoff  <= cdata[31:16];
                enable   <= cdata[9];
                req_n    <= (cdata[7:4] == 4'd0) ? 4'd1 : cdata[7:4];
                win_m    <= (cdata[3:0] == 4'd0) ? 4'd1 : cdata[3:0];
                hist     <= '0;
                hold_cnt <= '0;
                state    <= S_ARMED;
            end else if (!enable) begin
                hist     <= '0;
                hold_cnt <= '0;
                state    <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: state <= S_ARMED;
                    S_ARMED: begin
                        if (valid) begin
                            hist    <= {hist[13:0], match};
                            cand_ts <= sample_cnt;
                            state   <= S_EVAL;
                        end
                    end
                    S_EVAL: begin
                        if (push) begin
                            // A decision arriving alongside the detection counts toward the holdoff if one is set.
                            if (holdoff == 16'd0) begin
                                hist  <= valid ? {14'b0, match} : 15'b0;
                                state <= S_ARMED;
                            end else begin
                                hist <= '0;
                                if (valid) begin
                                    hold_cnt <= holdoff - 16'd1;
                                    state    <= (holdoff == 16'd1) ? S_ARMED : S_HOLD;
                                end else begin
                                    hold_cnt <= holdoff;
                                    state    <= S_HOLD;
                                end
                            end
                        end else begin
                            if (valid) hist <= {hist[13:0], match};
                            state <= S_ARMED;
                        end
                    end
                    default: begin
                        if (valid) begin
                            hold_cnt <= hold_cnt - 16'd1;
                            if (hold_cnt == 16'd1) state <= S_ARMED;
                        end
                    end
                endcase
            end
        end
    end

    assign ev.ev_valid = ev_vld_q;
    assign ev.ev_ts    = head.ts;
    assign ev.ev_hits  = head.hits;

    assign debugbus = {state, hits, 3'(fifo_cnt), ev_vld_q, ev.ev_ready, valid, match, enable, 2'b00};
endmodule
